// File: rtl/ttt_move_sequencer_if.sv
// rtl/ttt_move_sequencer_if.sv - player, board and status signals of the tic-tac-toe move sequencer
interface ttt_move_sequencer_if;
  logic       new_game;
  logic       x_req;
  logic [1:0] x_row;
  logic [1:0] x_col;
  logic       x_ack;
  logic       x_err;
  logic       o_req;
  logic [1:0] o_row;
  logic [1:0] o_col;
  logic       o_ack;
  logic       o_err;
  logic       brd_set;
  logic       brd_reset;
  logic [1:0] brd_row;
  logic [1:0] brd_col;
  logic [8:0] brd_valid;
  logic [8:0] brd_symbol;
  logic [1:0] brd_state;
  logic       turn;
  logic [3:0] move_count;
  logic       timed_out;
  logic       game_over;

  modport master (
    output new_game, x_req, x_row, x_col, o_req, o_row, o_col,
           brd_valid, brd_symbol, brd_state,
    input  x_ack, x_err, o_ack, o_err, brd_set, brd_reset, brd_row, brd_col,
           turn, move_count, timed_out, game_over
  );

  modport slave (
    input  new_game, x_req, x_row, x_col, o_req, o_row, o_col,
           brd_valid, brd_symbol, brd_state,
    output x_ack, x_err, o_ack, o_err, brd_set, brd_reset, brd_row, brd_col,
           turn, move_count, timed_out, game_over
  );
endinterface

// File: rtl/ttt_move_sequencer.sv
// rtl/ttt_move_sequencer.sv - turn order, move legality, board strobe and new-game clear sequencing
module ttt_move_sequencer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int CLR_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  ttt_move_sequencer_if.slave bus
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       CLR_LAST    = 4'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN       = (TIMEOUT_CYCLES != 0);

  logic [2:0]       state;
  logic [3:0]       wait_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             brd_set;
  logic             brd_reset;
  logic [1:0]       brd_row;
  logic [1:0]       brd_col;
  logic             x_ack;
  logic             x_err;
  logic             o_ack;
  logic             o_err;
  logic             turn;
  logic [3:0]       move_count;
  logic             timed_out;
  logic             x_blk;
  logic             o_blk;
  logic             ng_pend;

  logic       cur_req;
  logic       cur_blk;
  logic [1:0] cur_row;
  logic [1:0] cur_col;
  logic [3:0] cur_idx;
  logic       cell_busy;
  logic       cur_legal;

  // Symbols are tracked by the board itself; only occupancy matters here.
  logic unused_symbol;
  assign unused_symbol = ^bus.brd_symbol;

  always_comb begin
    cur_req   = turn ? bus.x_req : bus.o_req;
    cur_blk   = turn ? x_blk     : o_blk;
    cur_row   = turn ? bus.x_row : bus.o_row;
    cur_col   = turn ? bus.x_col : bus.o_col;
    cur_idx   = {2'b00, cur_row - 2'd1} * 4'd3 + {2'b00, cur_col - 2'd1};
    cell_busy = |(bus.brd_valid & (9'b1 << cur_idx));
    cur_legal = (cur_row != 2'd0) && (cur_col != 2'd0) && !cell_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      wait_cnt   <= 4'd0;
      to_cnt     <= '0;
      brd_set    <= 1'b0;
      brd_reset  <= 1'b1;
      brd_row    <= 2'd0;
      brd_col    <= 2'd0;
      x_ack      <= 1'b0;
      x_err      <= 1'b0;
      o_ack      <= 1'b0;
      o_err      <= 1'b0;
      turn       <= 1'b1;
      move_count <= 4'd0;
      timed_out  <= 1'b0;
      x_blk      <= 1'b0;
      o_blk      <= 1'b0;
      ng_pend    <= 1'b0;
    end else begin
      brd_set <= 1'b0;
      x_ack   <= 1'b0;
      x_err   <= 1'b0;
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      // A rejected player stays blocked until it releases its request.
      if (!bus.x_req) x_blk <= 1'b0;
      if (!bus.o_req) o_blk <= 1'b0;

      if ((bus.new_game || ng_pend) && state != S_ISSUE) begin
        state      <= S_CLEAR;
        wait_cnt   <= 4'd0;
        to_cnt     <= '0;
        brd_reset  <= 1'b1;
        turn       <= 1'b1;
        move_count <= 4'd0;
        timed_out  <= 1'b0;
        ng_pend    <= 1'b0;
      end else begin
        // The strobe cycle is never cut short; the clear follows it.
        if (bus.new_game) ng_pend <= 1'b1;
        case (state)
          S_CLEAR: begin
            if (wait_cnt == CLR_LAST) begin
              wait_cnt  <= 4'd0;
              brd_reset <= 1'b0;
              state     <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
          S_IDLE: begin
            if (cur_req && !cur_blk) begin
              if (cur_legal) begin
                brd_row <= cur_row;
                brd_col <= cur_col;
                to_cnt  <= '0;
                state   <= S_ISSUE;
              end else if (turn) begin
                x_err <= 1'b1;
                x_blk <= 1'b1;
              end else begin
                o_err <= 1'b1;
                o_blk <= 1'b1;
              end
            end else if (!cur_req && TO_EN) begin
              if (to_cnt == TO_LAST) begin
                timed_out <= 1'b1;
                state     <= S_OVER;
              end
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_ISSUE: begin
            brd_set <= 1'b1;
            if (turn) x_ack <= 1'b1;
            else      o_ack <= 1'b1;
            if (move_count != 4'd9) move_count <= move_count + 4'd1;
            wait_cnt <= 4'd0;
            state    <= S_SETTLE;
          end
          S_SETTLE: begin
            if (wait_cnt == SETTLE_LAST) begin
              wait_cnt <= 4'd0;
              if (bus.brd_state != 2'b00) begin
                state <= S_OVER;
              end else begin
                turn   <= ~turn;
                to_cnt <= '0;
                state  <= S_IDLE;
              end
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
          S_OVER: begin
            if (bus.x_req && !x_blk) begin
              x_err <= 1'b1;
              x_blk <= 1'b1;
            end
            if (bus.o_req && !o_blk) begin
              o_err <= 1'b1;
              o_blk <= 1'b1;
            end
          end
          default: state <= S_CLEAR;
        endcase
      end
    end
  end

  assign bus.brd_set    = brd_set;
  assign bus.brd_reset  = brd_reset;
  assign bus.brd_row    = brd_row;
  assign bus.brd_col    = brd_col;
  assign bus.x_ack      = x_ack;
  assign bus.x_err      = x_err;
  assign bus.o_ack      = o_ack;
  assign bus.o_err      = o_err;
  assign bus.turn       = turn;
  assign bus.move_count = move_count;
  assign bus.timed_out  = timed_out;
  assign bus.game_over  = (bus.brd_state != 2'b00) || timed_out;

endmodule
